reg_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared register bus (write/read/addr/wdata in, registered rdata out) feeding the I3C characteristic-register blocks (BCR and later DCR/CCC registers).
- Multiple requesters (host CPU port, CCC engine, ...) issue single-beat read or write transactions.
- The block serialises them, drives one bus strobe per transaction, captures read data after the register block's fixed read latency, and returns a one-cycle ack.

---
 rtl/reg_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_bus_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared register bus. Serialises
// single-beat read/write requests, issues one bus strobe each and acks the owner.
module reg_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_req_we,
  input  logic [NUM_REQ*32-1:0] i_req_addr,
  input  logic [NUM_REQ*32-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]    o_ack,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [31:0]           o_rdata,
  output logic                  o_busy,
  output logic                  o_bus_write,
  output logic                  o_bus_read,
  output logic [31:0]           o_bus_addr,
  output logic [31:0]           o_bus_wdata,
  input  logic [31:0]           i_bus_rdata
);

  // Handshake: a requester holds i_req (level) with stable we/addr/wdata until
  // its one-cycle o_ack; i_req must be low in the cycle after o_ack or a new
  // transaction starts. A request is committed once sampled in IDLE.

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, idx_q, win_idx;
  logic               win_valid, win_we;
  logic [31:0]        win_addr, win_wdata;
  logic               we_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]   cnt_q;

  // First set request searching upward from ptr_q+1 with wrap-around.
  always_comb begin
    int cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_valid && i_req[cand]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(cand);
        win_we    = i_req_we[cand];
        win_addr  = i_req_addr[cand*32 +: 32];
        win_wdata = i_req_wdata[cand*32 +: 32];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ISSUE;
      ISSUE:   state_d = we_q ? ACK : WAIT;
      WAIT:    if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            idx_q   <= win_idx;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
          end
        end
        ISSUE: if (!we_q) cnt_q <= CNT_W'(RD_LATENCY - 1);
        WAIT: begin
          if (cnt_q == '0) rdata_q <= i_bus_rdata;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ACK:     ptr_q <= idx_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy      = (state_q != IDLE);
    o_grant     = '0;
    o_ack       = '0;
    o_bus_write = 1'b0;
    o_bus_read  = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    if (state_q != IDLE) o_grant[idx_q] = 1'b1;
    if (state_q == ISSUE) begin
      o_bus_write = we_q;
      o_bus_read  = !we_q;
      o_bus_addr  = addr_q;
      o_bus_wdata = wdata_q;
    end
    if (state_q == ACK) o_ack[idx_q] = 1'b1;
  end

  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: a 2-requester/latency-1 instance with a
// BCR-style register model, and a 3-requester/latency-3 instance.
module tb_reg_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Instance A: NUM_REQ=2, RD_LATENCY=1
  logic [1:0]  req_a, we_a, ack_a, grant_a;
  logic [63:0] addr_a, wdata_a;
  logic [31:0] rdata_a, bus_addr_a, bus_wdata_a, bus_rdata_a;
  logic        busy_a, bus_write_a, bus_read_a;

  // Instance B: NUM_REQ=3, RD_LATENCY=3
  logic [2:0]  req_b, we_b, ack_b, grant_b;
  logic [95:0] addr_b, wdata_b;
  logic [31:0] rdata_b, bus_addr_b, bus_wdata_b, bus_rdata_b;
  logic        busy_b, bus_write_b, bus_read_b;

  reg_bus_arbiter #(.NUM_REQ(2), .RD_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_req_we(we_a),
    .i_req_addr(addr_a), .i_req_wdata(wdata_a), .o_ack(ack_a), .o_grant(grant_a),
    .o_rdata(rdata_a), .o_busy(busy_a), .o_bus_write(bus_write_a),
    .o_bus_read(bus_read_a), .o_bus_addr(bus_addr_a), .o_bus_wdata(bus_wdata_a),
    .i_bus_rdata(bus_rdata_a)
  );

  reg_bus_arbiter #(.NUM_REQ(3), .RD_LATENCY(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_req_we(we_b),
    .i_req_addr(addr_b), .i_req_wdata(wdata_b), .o_ack(ack_b), .o_grant(grant_b),
    .o_rdata(rdata_b), .o_busy(busy_b), .o_bus_write(bus_write_b),
    .o_bus_read(bus_read_b), .o_bus_addr(bus_addr_b), .o_bus_wdata(bus_wdata_b),
    .i_bus_rdata(bus_rdata_b)
  );

  // BCR model: one 8-bit register at address 0, registered read (latency 1).
  logic [7:0] bcr = 8'h00;
  always @(posedge clk) begin
    if (bus_write_a && bus_addr_a == 32'h0) bcr <= bus_wdata_a[7:0];
    bus_rdata_a <= (bus_read_a && bus_addr_a == 32'h0) ? {24'h0, bcr} : 32'h0;
  end

  // Three-stage delayed target returning 0x5A for any read.
  logic [31:0] pipe1 = '0, pipe2 = '0;
  always @(posedge clk) begin
    pipe1       <= bus_read_b ? 32'h5A : 32'h0;
    pipe2       <= pipe1;
    bus_rdata_b <= pipe2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] prev_grant;
    logic [1:0] exp_grant;
    rst_n = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    bus_rdata_b = '0; bus_rdata_a = '0;
    step(); step();
    check("rst_busy", 32'(busy_a), 0);
    check("rst_grant", 32'(grant_a), 0);
    check("rst_ack", 32'(ack_a), 0);
    check("rst_strobes", {30'h0, bus_write_a, bus_read_a}, 0);
    check("rst_rdata", rdata_a, 0);
    rst_n = 1'b1;
    step();

    // Req0 write 0xA5 to addr 0
    req_a = 2'b01; we_a = 2'b01; addr_a[31:0] = 32'h0; wdata_a[31:0] = 32'hA5;
    check("w_idle_busy", 32'(busy_a), 0);
    step();
    check("w_strobe", {30'h0, bus_write_a, bus_read_a}, 32'h2);
    check("w_addr", bus_addr_a, 32'h0);
    check("w_wdata", bus_wdata_a, 32'hA5);
    check("w_grant", 32'(grant_a), 32'h1);
    check("w_ack_early", 32'(ack_a), 0);
    req_a = 2'b00;
    step();
    check("w_ack", 32'(ack_a), 32'h1);
    check("w_strobe_off", {30'h0, bus_write_a, bus_read_a}, 0);
    check("w_rdata", rdata_a, 0);
    step();
    check("w_done_busy", 32'(busy_a), 0);
    check("w_done_ack", 32'(ack_a), 0);

    // Req1 read addr 0
    req_a = 2'b10; we_a = 2'b00; addr_a[63:32] = 32'h0;
    step();
    check("r_strobe", {30'h0, bus_write_a, bus_read_a}, 32'h1);
    check("r_grant_t1", 32'(grant_a), 32'h2);
    req_a = 2'b00;
    step();
    check("r_grant_t2", 32'(grant_a), 32'h2);
    check("r_strobe_t2", {30'h0, bus_write_a, bus_read_a}, 0);
    check("r_addr_t2", bus_addr_a, 0);
    check("r_ack_t2", 32'(ack_a), 0);
    step();
    check("r_ack", 32'(ack_a), 32'h2);
    check("r_grant_t3", 32'(grant_a), 32'h2);
    check("r_rdata", rdata_a, 32'hA5);
    step();

    // Req1 served last; both rise together -> req0 (undefined addr 4) first
    req_a = 2'b11; we_a = 2'b00; addr_a = {32'h0, 32'h4};
    step();
    check("sim_grant0", 32'(grant_a), 32'h1);
    check("sim_addr0", bus_addr_a, 32'h4);
    req_a = 2'b10;
    step();
    step();
    check("sim_ack0", 32'(ack_a), 32'h1);
    check("undef_rdata", rdata_a, 0);
    step();
    step();
    check("sim_grant1", 32'(grant_a), 32'h2);
    req_a = 2'b00;
    step();
    step();
    check("sim_ack1", 32'(ack_a), 32'h2);
    check("sim_rdata1", rdata_a, 32'hA5);
    step();

    // Req0 write to non-BCR address leaves rdata untouched
    req_a = 2'b01; we_a = 2'b01; addr_a[31:0] = 32'h8; wdata_a[31:0] = 32'h11;
    step();
    check("w2_addr", bus_addr_a, 32'h8);
    req_a = 2'b00;
    step();
    check("w2_ack", 32'(ack_a), 32'h1);
    check("w2_rdata_held", rdata_a, 32'hA5);
    step();

    // Req1 read aborted by reset during WAIT
    req_a = 2'b10; we_a = 2'b00; addr_a[63:32] = 32'h0;
    step();
    req_a = 2'b00;
    step();
    check("abort_busy_wait", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_a), 0);
    check("abort_grant", 32'(grant_a), 0);
    check("abort_rdata", rdata_a, 0);
    step();
    check("abort_no_ack", 32'(ack_a), 0);
    step();
    check("abort_no_ack2", 32'(ack_a), 0);
    rst_n = 1'b1;
    step();

    // Both held high from reset -> 0,1,0,1
    req_a = 2'b11; we_a = 2'b11; addr_a = {32'h20, 32'h20}; wdata_a = {32'h2, 32'h1};
    prev_grant = 2'b00;
    for (int k = 0; k < 4; k++) begin
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      check("rr_grant", 32'(grant_a), 32'(exp_grant));
      check("rr_no_repeat", 32'(grant_a != prev_grant), 1);
      check("rr_wdata", bus_wdata_a, (k % 2 == 0) ? 32'h1 : 32'h2);
      prev_grant = grant_a;
      step();
      check("rr_ack", 32'(ack_a), 32'(exp_grant));
      if (k == 3) req_a = 2'b00;
      step();
    end
    check("rr_idle", 32'(busy_a), 0);

    // Instance B: req2 read with latency 3
    req_b = 3'b100; we_b = 3'b000; addr_b[95:64] = 32'h10;
    check("b_idle_busy", 32'(busy_b), 0);
    step();
    check("b_strobe", {30'h0, bus_write_b, bus_read_b}, 32'h1);
    check("b_addr", bus_addr_b, 32'h10);
    check("b_grant", 32'(grant_b), 32'h4);
    check("b_busy1", 32'(busy_b), 1);
    req_b = 3'b000;
    for (int c = 2; c <= 4; c++) begin
      step();
      check("b_wait_busy", 32'(busy_b), 1);
      check("b_wait_ack", 32'(ack_b), 0);
      check("b_wait_grant", 32'(grant_b), 32'h4);
    end
    step();
    check("b_ack", 32'(ack_b), 32'h4);
    check("b_rdata", rdata_b, 32'h5A);
    check("b_busy5", 32'(busy_b), 1);
    step();
    check("b_done_busy", 32'(busy_b), 0);
    check("b_rdata_held", rdata_b, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
